fmrv32im_div_arb: RTL and testbench

Two-port arbiter and sequencer that shares one iterative divider between two requesters (e.g. the integer pipeline and a coprocessor port). It accepts DIV/DIVU/REM/REMU requests over valid/ready handshakes, selects one at a time with round-robin priority, and issues it to the divider as a one-cycle instruction pulse. It then captures the result into a per-port response register. Divide-by-zero requests complete without occupying the divider.

---
 rtl/fmrv32im_div_arb_pkg.sv | 26 ++
 rtl/fmrv32im_div_rr.sv | 35 +++
 rtl/fmrv32im_div_arb.sv | 175 +++++++++++++++++
 tb/tb_fmrv32im_div_arb.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmrv32im_div_arb_pkg.sv
// Shared encodings for the divider arbiter: request op codes, sequencer
// states and the divide-by-zero quotient.
package fmrv32im_div_arb_pkg;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    localparam logic [31:0] DIV_BY_ZERO_RD = 32'hFFFF_FFFF;

    // Result of a divide-by-zero: quotients saturate to all ones,
    // remainders return the dividend unchanged.
    function automatic logic [31:0] bypass_result(input logic [1:0] op,
                                                  input logic [31:0] rs1);
        return ((op == OP_REM) || (op == OP_REMU)) ? rs1 : DIV_BY_ZERO_RD;
    endfunction

endpackage

// File: rtl/fmrv32im_div_rr.sv
// Two-way round-robin grant. The pointer names the port that wins a tie;
// after every grant it moves to the port that was not granted.
module fmrv32im_div_rr (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] ELIG,
    input  logic       ADVANCE,
    output logic [1:0] GRANT,
    output logic       PTR
);

    // One-hot grant: the pointer port on a tie, otherwise the lone eligible port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        GRANT = 2'b00;
        if (ELIG == 2'b11) begin
            GRANT = PTR ? 2'b10 : 2'b01;
        end else begin
            GRANT = ELIG;
        end
    end

    // Pointer update: after a grant, the other port gets priority.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!RST_N) begin
            PTR <= 1'b0;
        end else if (ADVANCE) begin
            PTR <= GRANT[0];
        end
    end

endmodule

// File: rtl/fmrv32im_div_arb.sv
// Shares one iterative divider between two requesters. Requests are granted
// round-robin in IDLE, issued to the divider as a one-cycle pulse, and the
// result is captured into a per-port response slot. Divide-by-zero requests
// can complete directly in the arbiter.
module fmrv32im_div_arb
    import fmrv32im_div_arb_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [1:0]  REQ0_OP,
    input  logic [31:0] REQ0_RS1,
    input  logic [31:0] REQ0_RS2,

    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [1:0]  REQ1_OP,
    input  logic [31:0] REQ1_RS1,
    input  logic [31:0] REQ1_RS2,

    output logic        RSP0_VALID,
    input  logic        RSP0_READY,
    output logic [31:0] RSP0_RD,

    output logic        RSP1_VALID,
    input  logic        RSP1_READY,
    output logic [31:0] RSP1_RD,

    output logic        DIV_INST_DIV,
    output logic        DIV_INST_DIVU,
    output logic        DIV_INST_REM,
    output logic        DIV_INST_REMU,
    output logic [31:0] DIV_RS1,
    output logic [31:0] DIV_RS2,
    input  logic        DIV_WAIT,
    input  logic        DIV_READY,
    input  logic [31:0] DIV_RD
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  op_q;
    logic        owner_q;

    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_rd_q [2];

    logic [1:0]  slot_free;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        rr_ptr;

    logic        gnt_port;
    logic [1:0]  gnt_op;
    logic [31:0] gnt_rs1;
    logic [31:0] gnt_rs2;
    logic        gnt_bypass;
    logic        accept;
    logic [31:0] bypass_rd;
    logic [1:0]  slot_load;
    logic [31:0] slot_data;

    assign rsp_ready  = {RSP1_READY, RSP0_READY};
    assign RSP0_VALID = rsp_valid_q[0];
    assign RSP1_VALID = rsp_valid_q[1];
    assign RSP0_RD    = rsp_rd_q[0];
    assign RSP1_RD    = rsp_rd_q[1];

    // Eligibility: a port competes only in IDLE, out of reset, with a request
    // pending and somewhere to put its result.
    always_comb begin
        slot_free[0] = !rsp_valid_q[0] || rsp_ready[0];
        slot_free[1] = !rsp_valid_q[1] || rsp_ready[1];
        elig[0]      = RST_N && (state == IDLE) && REQ0_VALID && slot_free[0];
        elig[1]      = RST_N && (state == IDLE) && REQ1_VALID && slot_free[1];
    end

    fmrv32im_div_rr u_rr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ELIG    (elig),
        .ADVANCE (accept),
        .GRANT   (grant),
        .PTR     (rr_ptr)
    );

    // Granted-request mux, bypass detection and the combinational handshake.
    always_comb begin
        gnt_port   = (elig == 2'b11) ? rr_ptr : elig[1];
        gnt_op     = gnt_port ? REQ1_OP  : REQ0_OP;
        gnt_rs1    = gnt_port ? REQ1_RS1 : REQ0_RS1;
        gnt_rs2    = gnt_port ? REQ1_RS2 : REQ0_RS2;
        gnt_bypass = ZERO_BYPASS && (gnt_rs2 == 32'd0);
        bypass_rd  = bypass_result(gnt_op, gnt_rs1);
        REQ0_READY = grant[0] && (!DIV_WAIT || gnt_bypass);
        REQ1_READY = grant[1] && (!DIV_WAIT || gnt_bypass);
        accept     = REQ0_READY || REQ1_READY;
    end

    // Sequencer next state: bypassed requests never leave IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && !gnt_bypass) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (DIV_READY) state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture; divider operands change only for requests that use it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_q    <= OP_DIV;
            owner_q <= 1'b0;
            DIV_RS1 <= 32'd0;
            DIV_RS2 <= 32'd0;
        end else if (accept) begin
            op_q    <= gnt_op;
            owner_q <= gnt_port;
            if (!gnt_bypass) begin
                DIV_RS1 <= gnt_rs1;
                DIV_RS2 <= gnt_rs2;
            end
        end
    end

    // One start pulse, decoded from the latched op while in ISSUE.
    always_comb begin
        DIV_INST_DIV  = (state == ISSUE) && (op_q == OP_DIV);
        DIV_INST_DIVU = (state == ISSUE) && (op_q == OP_DIVU);
        DIV_INST_REM  = (state == ISSUE) && (op_q == OP_REM);
        DIV_INST_REMU = (state == ISSUE) && (op_q == OP_REMU);
    end

    // Slot load sources: a bypass at acceptance or a divider result in CAPT.
    always_comb begin
        slot_load[0] = (accept && gnt_bypass && !gnt_port) ||
                       ((state == CAPT) && !owner_q);
        slot_load[1] = (accept && gnt_bypass && gnt_port) ||
                       ((state == CAPT) && owner_q);
        slot_data    = (state == CAPT) ? DIV_RD : bypass_rd;
    end

    // Response slots: a load wins over a same-cycle consume.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST_N) begin
                rsp_valid_q[i] <= 1'b0;
                rsp_rd_q[i]    <= 32'd0;
            end else if (slot_load[i]) begin
                rsp_valid_q[i] <= 1'b1;
                rsp_rd_q[i]    <= slot_data;
            end else if (rsp_ready[i]) begin
                rsp_valid_q[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmrv32im_div_arb.sv
// Self-checking bench for fmrv32im_div_arb. A behavioural divider model
// answers issued ops; expected results come from plain RISC-V division
// arithmetic and expected latencies from the documented timing.
module tb_fmrv32im_div_arb;

    localparam logic [1:0] T_DIV  = 2'd0;
    localparam logic [1:0] T_DIVU = 2'd1;
    localparam logic [1:0] T_REM  = 2'd2;
    localparam logic [1:0] T_REMU = 2'd3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    always #5 CLK = ~CLK;

    // Main DUT (bypass enabled)
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_op  [2];
    logic [31:0] req_rs1 [2];
    logic [31:0] req_rs2 [2];
    logic [1:0]  rsp_ready = 2'b11;
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [31:0] rsp_rd [2];
    wire         d_div, d_divu, d_rem, d_remu;
    wire  [31:0] d_rs1, d_rs2;
    logic [31:0] d_rd;
    logic [5:0]  d_cnt;
    logic [31:0] d_res;
    wire         d_wait  = (d_cnt != 6'd0);
    wire         d_ready = (d_cnt == 6'd1);
    wire  [3:0]  d_vec   = {d_remu, d_rem, d_divu, d_div};

    // Second DUT (bypass disabled), only port 1 used
    logic        nb_valid = 1'b0;
    logic [1:0]  nb_op  = 2'd0;
    logic [31:0] nb_rs1 = 32'd0;
    logic [31:0] nb_rs2 = 32'd0;
    wire  [1:0]  nb_req_ready;
    wire  [1:0]  nb_rsp_valid;
    wire  [31:0] nb_rsp_rd0, nb_rsp_rd1;
    wire         n_div, n_divu, n_rem, n_remu;
    wire  [31:0] n_rs1, n_rs2;
    logic [31:0] n_rd;
    logic [5:0]  n_cnt;
    logic [31:0] n_res;
    wire         n_wait  = (n_cnt != 6'd0);
    wire         n_ready = (n_cnt == 6'd1);
    wire  [3:0]  n_vec   = {n_remu, n_rem, n_divu, n_div};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    logic [3:0]  pulse_vec;
    logic [31:0] pulse_rs1, pulse_rs2;

    fmrv32im_div_arb #(.ZERO_BYPASS(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(req_valid[0]), .REQ0_READY(req_ready[0]), .REQ0_OP(req_op[0]),
        .REQ0_RS1(req_rs1[0]), .REQ0_RS2(req_rs2[0]),
        .REQ1_VALID(req_valid[1]), .REQ1_READY(req_ready[1]), .REQ1_OP(req_op[1]),
        .REQ1_RS1(req_rs1[1]), .REQ1_RS2(req_rs2[1]),
        .RSP0_VALID(rsp_valid[0]), .RSP0_READY(rsp_ready[0]), .RSP0_RD(rsp_rd[0]),
        .RSP1_VALID(rsp_valid[1]), .RSP1_READY(rsp_ready[1]), .RSP1_RD(rsp_rd[1]),
        .DIV_INST_DIV(d_div), .DIV_INST_DIVU(d_divu), .DIV_INST_REM(d_rem),
        .DIV_INST_REMU(d_remu), .DIV_RS1(d_rs1), .DIV_RS2(d_rs2),
        .DIV_WAIT(d_wait), .DIV_READY(d_ready), .DIV_RD(d_rd)
    );

    fmrv32im_div_arb #(.ZERO_BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(1'b0), .REQ0_READY(nb_req_ready[0]), .REQ0_OP(2'd0),
        .REQ0_RS1(32'd0), .REQ0_RS2(32'd0),
        .REQ1_VALID(nb_valid), .REQ1_READY(nb_req_ready[1]), .REQ1_OP(nb_op),
        .REQ1_RS1(nb_rs1), .REQ1_RS2(nb_rs2),
        .RSP0_VALID(nb_rsp_valid[0]), .RSP0_READY(1'b1), .RSP0_RD(nb_rsp_rd0),
        .RSP1_VALID(nb_rsp_valid[1]), .RSP1_READY(1'b1), .RSP1_RD(nb_rsp_rd1),
        .DIV_INST_DIV(n_div), .DIV_INST_DIVU(n_divu), .DIV_INST_REM(n_rem),
        .DIV_INST_REMU(n_remu), .DIV_RS1(n_rs1), .DIV_RS2(n_rs2),
        .DIV_WAIT(n_wait), .DIV_READY(n_ready), .DIV_RD(n_rd)
    );

    // RISC-V M-extension division semantics
    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            T_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            T_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            T_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [1:0] vec_op(input logic [3:0] v);
        return v[1] ? T_DIVU : v[2] ? T_REM : v[3] ? T_REMU : T_DIV;
    endfunction

    // Divider latency from the start pulse: 34 cycles, or 2 for an unsigned
    // op whose divisor has bit 31 set; result lands at the end of the ready cycle.
    function automatic logic [5:0] div_lat(input logic [3:0] v, input logic [31:0] b);
        return ((v[1] || v[3]) && b[31]) ? 6'd2 : 6'd34;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural divider for the main DUT
    always @(posedge CLK) begin
        if (!RST_N) begin
            d_cnt <= 6'd0;
            d_rd  <= 32'd0;
            d_res <= 32'd0;
        end else if (d_cnt != 6'd0) begin
            d_cnt <= d_cnt - 6'd1;
            if (d_cnt == 6'd1) d_rd <= d_res;
        end else if (d_vec != 4'd0) begin
            d_cnt <= div_lat(d_vec, d_rs2);
            d_res <= ref_div(vec_op(d_vec), d_rs1, d_rs2);
        end
    end

    // Behavioural divider for the no-bypass DUT
    always @(posedge CLK) begin
        if (!RST_N) begin
            n_cnt <= 6'd0;
            n_rd  <= 32'd0;
            n_res <= 32'd0;
        end else if (n_cnt != 6'd0) begin
            n_cnt <= n_cnt - 6'd1;
            if (n_cnt == 6'd1) n_rd <= n_res;
        end else if (n_vec != 4'd0) begin
            n_cnt <= div_lat(n_vec, n_rs2);
            n_res <= ref_div(vec_op(n_vec), n_rs1, n_rs2);
        end
    end

    // Record start pulses seen on the main DUT
    always @(negedge CLK) begin
        if (d_vec != 4'd0) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
            pulse_vec = d_vec;
            pulse_rs1 = d_rs1;
            pulse_rs2 = d_rs2;
        end
    end

    // One request on port p: acceptance, response latency, result, pulse.
    task automatic run_req(input int p, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input bit exp_pulse, input logic [31:0] exp_rd,
                           input string name);
        int t, pc0;
        bit got;
        @(negedge CLK);
        req_op[p] = op; req_rs1[p] = a; req_rs2[p] = b; req_valid[p] = 1'b1;
        pc0 = pulse_cnt;
        #1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (req_ready[p]) got = 1'b1;
            else begin @(negedge CLK); #1; end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s accept: no REQ%0d_READY within 200 cycles", name, p);
            req_valid[p] = 1'b0;
            return;
        end
        t = cyc;
        @(negedge CLK);
        req_valid[p] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (rsp_valid[p]) got = 1'b1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s response: no RSP%0d_VALID within 100 cycles", name, p);
            return;
        end
        n_cmp++;
        if (cyc - t !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc - t, exp_lat);
        end
        n_cmp++;
        if (rsp_rd[p] !== exp_rd) begin
            n_bad++;
            $display("FAIL %s rd: got %h required %h", name, rsp_rd[p], exp_rd);
        end
        @(negedge CLK);
        n_cmp++;
        if (pulse_cnt !== pc0 + (exp_pulse ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s pulse count: got %0d required %0d", name,
                     pulse_cnt - pc0, exp_pulse ? 1 : 0);
        end
        if (exp_pulse) begin
            n_cmp++;
            if (pulse_cyc !== t + 1 || pulse_vec !== (4'b0001 << op) ||
                pulse_rs1 !== a || pulse_rs2 !== b) begin
                n_bad++;
                $display("FAIL %s pulse: cyc %0d vec %b rs %h/%h required cyc %0d vec %b rs %h/%h",
                         name, pulse_cyc - t, pulse_vec, pulse_rs1, pulse_rs2,
                         1, 4'b0001 << op, a, b);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = T_DIV; req_rs1[i] = 32'd9; req_rs2[i] = 32'd3;
        end
        repeat (3) @(negedge CLK);
        #1;
        n_cmp++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_rd[0] !== 32'd0 ||
            rsp_rd[1] !== 32'd0 || d_vec !== 4'd0 || d_rs1 !== 32'd0 || d_rs2 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset values: ready %b rsp_valid %b rd %h/%h inst %b rs %h/%h required all zero",
                     req_ready, rsp_valid, rsp_rd[0], rsp_rd[1], d_vec, d_rs1, d_rs2);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_both_at_reset_exit();
        int t0, t1, early_hits;
        bit got;
        @(negedge CLK);
        RST_N = 1'b0;
        req_op[0] = T_REMU; req_rs1[0] = 32'd100; req_rs2[0] = 32'd7;
        req_op[1] = T_DIVU; req_rs1[1] = 32'd100; req_rs2[1] = 32'd7;
        req_valid = 2'b11;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL both first grant: ready %b required 01", req_ready);
        end
        t0 = cyc;
        @(negedge CLK);
        req_valid[0] = 1'b0;
        early_hits = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (rsp_valid[0]) got = 1'b1;
            else begin
                if (req_ready[1]) early_hits++;
                @(negedge CLK);
            end
        end
        n_cmp++;
        if (!got || cyc - t0 !== 37 || rsp_rd[0] !== 32'd2) begin
            n_bad++;
            $display("FAIL both port0: valid %b lat %0d rd %h required 1 37 00000002",
                     got, cyc - t0, rsp_rd[0]);
        end
        n_cmp++;
        if (early_hits !== 0) begin
            n_bad++;
            $display("FAIL both port1 waits: early grants %0d required 0", early_hits);
        end
        n_cmp++;
        if (req_ready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL both port1 after capt: ready %b required 1", req_ready[1]);
        end
        t1 = cyc;
        @(negedge CLK);
        req_valid[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (rsp_valid[1]) got = 1'b1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!got || cyc - t1 !== 37 || rsp_rd[1] !== 32'd14) begin
            n_bad++;
            $display("FAIL both port1: valid %b lat %0d rd %h required 1 37 0000000e",
                     got, cyc - t1, rsp_rd[1]);
        end
    endtask

    task automatic test_div_negative();
        run_req(0, T_DIV, 32'hFFFF_FFF9, 32'd2, 37, 1'b1, 32'hFFFF_FFFD, "div_neg");
    endtask

    task automatic test_bypass();
        run_req(1, T_REM, 32'h8000_0001, 32'd0, 1, 1'b0, 32'h8000_0001, "bypass_rem");
        run_req(0, T_DIVU, 32'h0000_1234, 32'd0, 1, 1'b0, 32'hFFFF_FFFF, "bypass_divu");
    endtask

    task automatic test_no_bypass();
        int t;
        bit got, pulsed;
        @(negedge CLK);
        nb_op = T_REM; nb_rs1 = 32'h8000_0001; nb_rs2 = 32'd0; nb_valid = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (nb_req_ready[1]) got = 1'b1;
            else begin @(negedge CLK); #1; end
        end
        t = cyc;
        @(negedge CLK);
        nb_valid = 1'b0;
        pulsed = n_rem;
        n_cmp++;
        if (!got || !pulsed) begin
            n_bad++;
            $display("FAIL nobypass issue: accepted %b rem pulse %b required 1 1", got, pulsed);
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (nb_rsp_valid[1]) got = 1'b1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!got || cyc - t !== 37 || nb_rsp_rd1 !== 32'h8000_0001) begin
            n_bad++;
            $display("FAIL nobypass result: valid %b lat %0d rd %h required 1 37 80000001",
                     got, cyc - t, nb_rsp_rd1);
        end
    endtask

    task automatic test_early_finish();
        run_req(0, T_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5, 1'b1, 32'd1, "early_divu");
    endtask

    task automatic test_backpressure();
        int t, blocked;
        bit got;
        rsp_ready[0] = 1'b0;
        run_req(0, T_DIVU, 32'd50, 32'd5, 37, 1'b1, 32'd10, "bp_first");
        @(negedge CLK);
        req_op[0] = T_DIV; req_rs1[0] = 32'd9;  req_rs2[0] = 32'd3;
        req_op[1] = T_DIV; req_rs1[1] = 32'd20; req_rs2[1] = 32'd4;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL bp grant: ready %b required 10", req_ready);
        end
        t = cyc;
        @(negedge CLK);
        req_valid[1] = 1'b0;
        blocked = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (req_ready[0]) blocked++;
            if (rsp_valid[1]) got = 1'b1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!got || cyc - t !== 37 || rsp_rd[1] !== 32'd5 || blocked !== 0) begin
            n_bad++;
            $display("FAIL bp port1: valid %b lat %0d rd %h port0 grants %0d required 1 37 00000005 0",
                     got, cyc - t, rsp_rd[1], blocked);
        end
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_rd[0] !== 32'd10) begin
            n_bad++;
            $display("FAIL bp held slot: valid %b rd %h required 1 0000000a", rsp_valid[0], rsp_rd[0]);
        end
        rsp_ready[0] = 1'b1;
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp release: ready0 %b required 1", req_ready[0]);
        end
        t = cyc;
        @(negedge CLK);
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (rsp_valid[0]) got = 1'b1;
            else @(negedge CLK);
        end
        n_cmp++;
        if (!got || cyc - t !== 37 || rsp_rd[0] !== 32'd3) begin
            n_bad++;
            $display("FAIL bp port0: valid %b lat %0d rd %h required 1 37 00000003",
                     got, cyc - t, rsp_rd[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [4];
        logic [31:0] a   [4];
        logic [31:0] exp [4];
        for (int i = 0; i < 4; i++) begin
            ops[i] = 2'(i);
            a[i]   = $urandom;
            exp[i] = ref_div(ops[i], a[i], 32'd0);
        end
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            req_op[0] = ops[i]; req_rs1[0] = a[i]; req_rs2[0] = 32'd0; req_valid[0] = 1'b1;
            #1;
            n_cmp++;
            if (req_ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b accept %0d: ready %b required 1", i, req_ready[0]);
            end
            if (i > 0) begin
                n_cmp++;
                if (rsp_valid[0] !== 1'b1 || rsp_rd[0] !== exp[i-1]) begin
                    n_bad++;
                    $display("FAIL b2b rsp %0d: valid %b rd %h required 1 %h",
                             i - 1, rsp_valid[0], rsp_rd[0], exp[i-1]);
                end
            end
            @(negedge CLK);
        end
        req_valid[0] = 1'b0;
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_rd[0] !== exp[3]) begin
            n_bad++;
            $display("FAIL b2b rsp 3: valid %b rd %h required 1 %h", rsp_valid[0], rsp_rd[0], exp[3]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int p, sel, lat;
            logic [1:0]  op;
            logic [31:0] a, b;
            p   = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 4));
            a   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: b = $urandom | 32'h8000_0000;
                2: b = $urandom_range(1, 255);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if (b == 32'd0) lat = 1;
            else if ((op == T_DIVU || op == T_REMU) && b[31]) lat = 5;
            else lat = 37;
            run_req(p, op, a, b, lat, b != 32'd0, ref_div(op, a, b), "random");
        end
    endtask

    task automatic test_reset_mid_op();
        int t, pc0, stray;
        bit got;
        @(negedge CLK);
        req_op[1] = T_DIV; req_rs1[1] = 32'd1000; req_rs2[1] = 32'd3; req_valid[1] = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (req_ready[1]) got = 1'b1;
            else begin @(negedge CLK); #1; end
        end
        t = cyc;
        @(negedge CLK);
        req_valid[1] = 1'b0;
        while (cyc < t + 10) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        n_cmp++;
        if (!got || req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_rd[0] !== 32'd0 ||
            rsp_rd[1] !== 32'd0 || d_vec !== 4'd0 || d_rs1 !== 32'd0 || d_rs2 !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset values: accepted %b ready %b rsp_valid %b rd %h/%h inst %b rs %h/%h required 1 then all zero",
                     got, req_ready, rsp_valid, rsp_rd[0], rsp_rd[1], d_vec, d_rs1, d_rs2);
        end
        RST_N = 1'b1;
        pc0 = pulse_cnt;
        stray = 0;
        repeat (60) begin
            @(negedge CLK);
            if (rsp_valid !== 2'b00) stray++;
        end
        n_cmp++;
        if (stray !== 0 || pulse_cnt !== pc0) begin
            n_bad++;
            $display("FAIL midreset aborted: stray responses %0d pulses %0d required 0 0",
                     stray, pulse_cnt - pc0);
        end
        run_req(1, T_REMU, 32'd77, 32'd10, 37, 1'b1, 32'd7, "after_reset");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_op[i] = 2'd0; req_rs1[i] = 32'd0; req_rs2[i] = 32'd0;
        end
        test_reset();
        test_both_at_reset_exit();
        test_div_negative();
        test_bypass();
        test_no_bypass();
        test_early_finish();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
